// File: rtl/ws_array_seq.sv
// Tile sequencer for an NxN weight-stationary systolic array: loads weights row by row,
// clears accumulators, streams activations and skews per-column MAC enables.
module ws_array_seq #(
  parameter int N  = 4,
  parameter int KW = 16,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  output logic          busy,
  output logic          done,
  output logic          w_rd_en,
  output logic [AW-1:0] w_addr,
  output logic [N-1:0]  load_row,
  output logic          clr,
  output logic          act_rd_en,
  output logic [KW-1:0] act_addr,
  output logic [N-1:0]  en_col
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CLEAR  = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int              NM1        = N - 1;
  localparam logic [AW:0]     LOAD_LAST  = N[AW:0];
  localparam logic [AW:0]     DRAIN_LAST = NM1[AW:0];
  localparam logic [AW:0]     C_ONE      = {{AW{1'b0}}, 1'b1};
  localparam logic [KW-1:0]   K_ONE      = {{(KW-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]    ROW0       = {{(N-1){1'b0}}, 1'b1};

  state_t        state_r, state_s;
  logic [KW-1:0] k_r, k_s;
  logic [AW:0]   lcnt_r, lcnt_s;
  logic [KW-1:0] acnt_r, acnt_s;
  logic [AW:0]   dcnt_r, dcnt_s;

  logic          busy_r, busy_s, done_r, done_s, w_rd_en_r, w_rd_en_s;
  logic [AW-1:0] w_addr_r, w_addr_s;
  logic [N-1:0]  load_row_r, load_row_s;
  logic          clr_r, clr_s, act_rd_en_r, act_rd_en_s;
  logic [KW-1:0] act_addr_r, act_addr_s;
  logic [N-1:0]  en_sr_r;

  function automatic logic [N-1:0] row_onehot(input logic [AW:0] idx);
    return ROW0 << idx;
  endfunction

  // State, latched tile length and phase counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      k_r     <= '0;
      lcnt_r  <= '0;
      acnt_r  <= '0;
      dcnt_r  <= '0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
      lcnt_r  <= lcnt_s;
      acnt_r  <= acnt_s;
      dcnt_r  <= dcnt_s;
    end
  end

  // Next-state and counter sequencing
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    lcnt_s  = lcnt_r;
    acnt_s  = acnt_r;
    dcnt_s  = dcnt_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_LOAD;
          k_s     = k_len;
          lcnt_s  = '0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (lcnt_r == LOAD_LAST) begin
          state_s = S_CLEAR;
          lcnt_s  = '0;
        end else begin
          lcnt_s = lcnt_r + C_ONE;
        end
      end
      S_CLEAR: begin
        acnt_s = '0;
        if (k_r != '0) begin
          state_s = S_STREAM;
        end else begin
          state_s = S_DONE;
        end
      end
      S_STREAM: begin
        if (acnt_r == k_r - K_ONE) begin
          state_s = S_DRAIN;
          acnt_s  = '0;
          dcnt_s  = '0;
        end else begin
          acnt_s = acnt_r + K_ONE;
        end
      end
      S_DRAIN: begin
        if (dcnt_r == DRAIN_LAST) begin
          state_s = S_DONE;
          dcnt_s  = '0;
        end else begin
          dcnt_s = dcnt_r + C_ONE;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so every port comes straight from a flop
  always_comb begin
    busy_s      = (state_s != S_IDLE);
    done_s      = (state_s == S_DONE);
    w_rd_en_s   = (state_s == S_LOAD) && (lcnt_s < LOAD_LAST);
    w_addr_s    = w_rd_en_s ? lcnt_s[AW-1:0] : '0;
    // Weight data arrives one cycle after its read, so row i-1 is written at step i
    if ((state_s == S_LOAD) && (lcnt_s != '0)) begin
      load_row_s = row_onehot(lcnt_s - C_ONE);
    end else begin
      load_row_s = '0;
    end
    clr_s       = (state_s == S_CLEAR);
    act_rd_en_s = (state_s == S_STREAM);
    act_addr_s  = act_rd_en_s ? acnt_s : '0;
  end

  // Output registers and the column-enable skew line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      w_rd_en_r   <= 1'b0;
      w_addr_r    <= '0;
      load_row_r  <= '0;
      clr_r       <= 1'b0;
      act_rd_en_r <= 1'b0;
      act_addr_r  <= '0;
      en_sr_r     <= '0;
    end else begin
      busy_r      <= busy_s;
      done_r      <= done_s;
      w_rd_en_r   <= w_rd_en_s;
      w_addr_r    <= w_addr_s;
      load_row_r  <= load_row_s;
      clr_r       <= clr_s;
      act_rd_en_r <= act_rd_en_s;
      act_addr_r  <= act_addr_s;
      en_sr_r     <= {en_sr_r[N-2:0], act_rd_en_r};
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign w_rd_en   = w_rd_en_r;
  assign w_addr    = w_addr_r;
  assign load_row  = load_row_r;
  assign clr       = clr_r;
  assign act_rd_en = act_rd_en_r;
  assign act_addr  = act_addr_r;
  assign en_col    = en_sr_r;

  ws_array_seq_chk #(.N(N), .AW(AW)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_rd_en   (w_rd_en_r),
    .w_addr    (w_addr_r),
    .load_row  (load_row_r),
    .clr       (clr_r),
    .act_rd_en (act_rd_en_r),
    .en_col    (en_sr_r),
    .done      (done_r)
  );
endmodule

// Protocol invariants for ws_array_seq: phase exclusivity and load/enable schedules.
module ws_array_seq_chk #(
  parameter int N  = 4,
  parameter int AW = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          w_rd_en,
  input logic [AW-1:0] w_addr,
  input logic [N-1:0]  load_row,
  input logic          clr,
  input logic          act_rd_en,
  input logic [N-1:0]  en_col,
  input logic          done
);
  localparam logic [N-1:0] ROW0 = {{(N-1){1'b0}}, 1'b1};

  a_load_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !((|load_row) && ((|en_col) || clr)));
  a_clr_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(clr && (|en_col)));
  a_load_sched: assert property (@(posedge clk) disable iff (!rst_n)
    load_row == ($past(w_rd_en) ? (ROW0 << $past(w_addr)) : {N{1'b0}}));
  a_en_sched: assert property (@(posedge clk) disable iff (!rst_n)
    en_col == {$past(en_col[N-2:0]), $past(act_rd_en)});
  a_done_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    done |-> (en_col == {N{1'b0}}));
endmodule

// File: tb/tb_ws_array_seq.sv
// Bench for ws_array_seq: cycle-exact timeline model for N=4 and N=8 instances plus a done scoreboard.
module tb_ws_array_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic        start4, busy4, done4, w_rd_en4, clr4, act_rd_en4;
  logic [15:0] k_len4, act_addr4;
  logic [1:0]  w_addr4;
  logic [3:0]  load_row4, en_col4;

  logic        start8, busy8, done8, w_rd_en8, clr8, act_rd_en8;
  logic [15:0] k_len8, act_addr8;
  logic [2:0]  w_addr8;
  logic [7:0]  load_row8, en_col8;

  ws_array_seq #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .k_len(k_len4), .busy(busy4), .done(done4),
    .w_rd_en(w_rd_en4), .w_addr(w_addr4), .load_row(load_row4), .clr(clr4),
    .act_rd_en(act_rd_en4), .act_addr(act_addr4), .en_col(en_col4)
  );

  ws_array_seq #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .k_len(k_len8), .busy(busy8), .done(done8),
    .w_rd_en(w_rd_en8), .w_addr(w_addr8), .load_row(load_row8), .clr(clr8),
    .act_rd_en(act_rd_en8), .act_addr(act_addr8), .en_col(en_col8)
  );

  // Common packing: busy, done, w_rd_en, w_addr[8], load_row[8], clr, act_rd_en, act_addr[16], en_col[8]
  logic [63:0] obs4, obs8;
  assign obs4 = {19'd0, busy4, done4, w_rd_en4, 6'd0, w_addr4, 4'd0, load_row4, clr4,
                 act_rd_en4, act_addr4, 4'd0, en_col4};
  assign obs8 = {19'd0, busy8, done8, w_rd_en8, 5'd0, w_addr8, load_row8, clr8,
                 act_rd_en8, act_addr8, en_col8};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs t cycles after the start cycle of a tile of length k on an n x n array
  function automatic logic [63:0] model(input int n, input int t, input int k);
    int          dc;
    logic        b, dn, wr, cl, ar;
    logic [7:0]  wa, lr, en;
    logic [15:0] aa;
    dc = (k == 0) ? n + 3 : 2 * n + 3 + k;
    b  = (t >= 1) && (t <= dc);
    dn = (t == dc);
    wr = (t >= 1) && (t <= n);
    wa = wr ? 8'(t - 1) : 8'd0;
    lr = ((t >= 2) && (t <= n + 1)) ? 8'(32'd1 << (t - 2)) : 8'd0;
    cl = (t == n + 2);
    ar = (t >= n + 3) && (t <= n + 2 + k);
    aa = ar ? 16'(t - n - 3) : 16'd0;
    en = 8'd0;
    for (int c = 0; c < n; c++) en[c] = (t >= n + 4 + c) && (t <= n + 3 + c + k);
    return {19'd0, b, dn, wr, wa, lr, cl, ar, aa, en};
  endfunction

  int t0 [2];
  int kk [2];
  bit act [2];
  int q4 [$];
  int q8 [$];
  int en_cnt [8];

  // Per-cycle comparison against the timeline model; accepted starts push their done cycle
  always @(negedge clk) begin : mon
    int          n, t, dc, kli, exp_d;
    logic [63:0] o;
    logic        st, dn;
    for (int d = 0; d < 2; d++) begin
      n   = (d == 1) ? 8 : 4;
      o   = (d == 1) ? obs8 : obs4;
      st  = (d == 1) ? start8 : start4;
      dn  = (d == 1) ? done8 : done4;
      kli = (d == 1) ? int'(k_len8) : int'(k_len4);
      if (!rst_n) begin
        act[d] = 1'b0;
        if (d == 1) q8.delete(); else q4.delete();
        check((d == 1) ? "rst8" : "rst4", o, 64'd0);
      end else begin
        t  = act[d] ? cyc - t0[d] : -1;
        dc = (kk[d] == 0) ? n + 3 : 2 * n + 3 + kk[d];
        check((d == 1) ? "out8" : "out4", o, model(n, t, kk[d]));
        if (d == 1) begin
          for (int c = 0; c < 8; c++) if (en_col8[c]) en_cnt[c]++;
        end
        if (dn) begin
          if (d == 1) begin
            exp_d = (q8.size() != 0) ? q8.pop_front() : -1;
            check("done8_cyc", 64'(cyc), 64'(exp_d));
            for (int c = 0; c < 8; c++) check("en_cnt8", 64'(en_cnt[c]), 64'(kk[1]));
          end else begin
            exp_d = (q4.size() != 0) ? q4.pop_front() : -1;
            check("done4_cyc", 64'(cyc), 64'(exp_d));
          end
        end
        if (st && (!act[d] || t > dc)) begin
          act[d] = 1'b1;
          t0[d]  = cyc;
          kk[d]  = kli;
          if (d == 1) begin
            q8.push_back(cyc + ((kli == 0) ? n + 3 : 2 * n + 3 + kli));
            for (int c = 0; c < 8; c++) en_cnt[c] = 0;
          end else begin
            q4.push_back(cyc + ((kli == 0) ? n + 3 : 2 * n + 3 + kli));
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic start_tile4(input int k);
    start4 = 1'b1;
    k_len4 = 16'(k);
    step(1);
    start4 = 1'b0;
  endtask

  task automatic start_tile8(input int k);
    start8 = 1'b1;
    k_len8 = 16'(k);
    step(1);
    start8 = 1'b0;
  endtask

  initial begin
    int base, k;
    rst_n  = 1'b0;
    start4 = 1'b0;
    start8 = 1'b0;
    k_len4 = 16'd0;
    k_len8 = 16'd0;
    step(3);
    rst_n = 1'b1;
    step(10);

    // Nominal tile, k=8
    base = cyc;
    start_tile4(8);
    goto(base + 22);

    // Empty tile, k=0
    base = cyc;
    start_tile4(0);
    goto(base + 10);

    // Starts during a tile are ignored; a start right after done is taken
    base = cyc;
    start_tile4(8);
    goto(base + 3);
    start_tile4(5);
    goto(base + 10);
    start_tile4(5);
    goto(base + 20);
    start_tile4(8);
    goto(base + 42);

    // Asynchronous reset mid-tile, then a fresh tile
    base = cyc;
    start_tile4(8);
    goto(base + 9);
    #1 rst_n = 1'b0;
    goto(base + 12);
    rst_n = 1'b1;
    goto(base + 13);
    start_tile4(8);
    goto(base + 35);

    // Back-to-back random tiles on the 8x8 instance
    for (int i = 0; i < 50; i++) begin
      k = (i == 0) ? 1 : (i == 1) ? 300 : int'($urandom_range(1, 300));
      start_tile8(k);
      for (int w = 0; w < 400 && q8.size() != 0; w++) step(1);
      step(int'($urandom_range(0, 2)));
    end

    step(5);
    check("q4_pending", 64'(q4.size()), 64'd0);
    check("q8_pending", 64'(q8.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ws_array_seq.md
# ws_array_seq

Sequencer for an N×N weight-stationary systolic array of `pe` cells. On a `start` pulse it runs one tile:
- loads the stationary weights one array row per cycle from the weight buffer;
- clears all accumulators;
- streams `k_len` activation vectors from the activation buffer;
- generates per-column MAC enables skewed to match the horizontal activation pipeline (PIPE=1);
- drains the array and pulses `done` when every accumulator holds its final result.

It sits between the layer scheduler (`start`/`done`) and the array plus its two on-chip buffers.

## Interface
Parameters:
- `N`, 4: array dimension (rows = columns = N), N ≥ 2
- `KW`, 16: width of `k_len` and `act_addr`
- `AW`, `$clog2(N)`: width of `w_addr`

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin tile; sampled only in IDLE
- `k_len`  in  KW  activation vector count; latched on accepted `start`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse; accumulators valid
- `w_rd_en`  out  1  weight buffer read strobe; data returns next cycle
- `w_addr`  out  AW  weight row address
- `load_row`  out  N  one-hot; bit r drives `load_weight` of every PE in row r
- `clr`  out  1  accumulator clear, broadcast to all PEs
- `act_rd_en`  out  1  activation buffer read strobe; data returns next cycle
- `act_addr`  out  KW  activation vector address
- `en_col`  out  N  bit c drives `en` of every PE in column c

## Operation
- States: IDLE → LOAD → CLEAR → STREAM → DRAIN → DONE → IDLE.
- IDLE:
  - `start`=1 latches `k_len` into `k_reg`, goes to LOAD.
  - `start` in any other state is ignored; no queuing.
- LOAD: N+1 cycles, counter i = 0..N.
  - For i < N: `w_rd_en`=1, `w_addr`=i.
  - For i ≥ 1: `load_row` = one-hot bit (i−1).
  - Then go to CLEAR.
- CLEAR: 1 cycle, `clr`=1.
  - Go to STREAM if `k_reg` ≠ 0.
  - Go to DONE if `k_reg` = 0.
- STREAM: `k_reg` cycles, counter j = 0..k_reg−1.
  - `act_rd_en`=1, `act_addr`=j.
  - Then go to DRAIN.
- DRAIN: exactly N cycles, then go to DONE.
- DONE: 1 cycle, `done`=1, then go to IDLE.
- Enable skew: `en_col[c]` = `act_rd_en` delayed by 1+c cycles.
  - The 1 covers buffer read latency; c covers the `a_out` pipeline hops.
  - Implement as an N-deep shift register fed by `act_rd_en`.
- Invariants, checked by assertions:
  - `load_row` ≠ 0 never overlaps `en_col` ≠ 0 or `clr`.
  - `clr` never overlaps `en_col` ≠ 0.
  - `load_row` and `en_col` change only via their defined schedules.
- Counters:
  - LOAD counter is AW+1 bits.
  - STREAM counter is KW bits and stops at `k_reg`−1; there is no wrap.
  - `k_len` = 2^KW−1 is legal.

## Timing
- Reset:
  - All outputs are 0; state is IDLE.
  - `k_reg`, all counters and the skew shift register are 0.
  - Reset assertion mid-tile takes effect immediately (async). The tile is abandoned with no `done`.
  - PE weights and accumulators are not touched by this block.
- Timeline: `start` accepted at edge of cycle 0, k = `k_reg`.
  - LOAD: cycles 1..N+1.
  - CLEAR: cycle N+2.
  - STREAM: cycles N+3..N+2+k.
  - DRAIN: cycles N+3+k..2N+2+k.
  - `done`: cycle 2N+3+k.
- k = 0: `done` at cycle N+3; `act_rd_en` and `en_col` stay 0.
- `busy` is 1 from cycle 1 through the `done` cycle inclusive.
- A new `start` is accepted at the earliest one cycle after `done`.
- Last `en_col[N−1]` pulse falls in the final DRAIN cycle; `en_col` is 0 when `done`=1.
- All outputs are registered (driven from flops) with no combinational path from `start` or `k_len`.

## Test plan
- Reset, N=4, no `start` for 10 cycles:
  - All outputs stay 0, `busy`=0.
- N=4, `k_len`=8, `start` at cycle 0:
  - `w_addr` 0,1,2,3 on cycles 1–4.
  - `load_row` 0001,0010,0100,1000 on cycles 2–5.
  - `clr` on cycle 6.
  - `act_addr` 0..7 on cycles 7–14.
  - `en_col[0]` on cycles 8–15; `en_col[3]` on cycles 11–18.
  - `done` on cycle 19.
- N=4, `k_len`=0:
  - LOAD/CLEAR as above; `done` on cycle 7.
  - `en_col` and `act_rd_en` stay 0.
- `start` pulsed at cycles 3 and 10 during a `k_len`=8 tile:
  - Both ignored; single `done` at cycle 19.
  - A `start` at cycle 20 begins a new tile with `done` at cycle 39.
- `rst_n` low at cycle 9 of a `k_len`=8 tile, released at cycle 12:
  - Outputs go 0 asynchronously at assertion; no `done`.
  - A fresh `start` at cycle 13 completes at cycle 32.
- Random `k_len` 1..300, N=8, 50 tiles with a scoreboard:
  - `done` = 2N+3+k after `start`.
  - Overlap assertions never fire.
  - Each `en_col[c]` has exactly k pulses.
